// File: rtl/sp_fwd_unit.sv
// Stack-pointer forwarding and update unit.
// Picks the effective SP from the youngest valid in-flight copy or the
// architectural SP. It computes push/pop addresses and the next SP into
// registered outputs. An illegal op latches a fault state, and the fault
// state holds until software clears it.
module sp_fwd_unit #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      STAGES      = 2,
  parameter logic [WIDTH-1:0] SP_RESET    = WIDTH'(32'h000FFFFF),
  parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h000F0000),
  parameter int unsigned      STEP        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [STAGES-1:0]        fwd_valid,
  input  logic [STAGES*WIDTH-1:0]  fwd_value,
  input  logic                     commit_valid,
  input  logic [WIDTH-1:0]         commit_value,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     fault_clr,
  output logic [WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]         sp_new,
  output logic                     op_valid,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     fault
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  // Bounds are compared one bit wider so that a wrapped sum can never look legal.
  localparam logic [WIDTH:0]   StepExt   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   PushBound = {1'b0, STACK_LIMIT} + StepExt;
  localparam logic [WIDTH:0]   PopBound  = {1'b0, SP_RESET};
  localparam logic [WIDTH-1:0] StepW     = WIDTH'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] sp_arch_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] sp_new_q;
  logic             op_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic [WIDTH-1:0] eff;
  logic [WIDTH:0]   pop_sum;
  logic             push_req;
  logic             pop_req;
  logic             push_ok;
  logic             pop_ok;

  // Effective SP: the lowest-index valid stage wins, so it is written last.
  always_comb begin
    eff = sp_arch_q;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (fwd_valid[i]) begin
        eff = fwd_value[i*WIDTH +: WIDTH];
      end
    end
  end

  // Op decode and bound checks. Simultaneous push and pop decode as no op.
  always_comb begin
    push_req = push & ~pop;
    pop_req  = pop & ~push;
    pop_sum  = {1'b0, eff} + StepExt;
    push_ok  = ({1'b0, eff} >= PushBound);
    pop_ok   = (pop_sum <= PopBound);
  end

  // Architectural SP, fault FSM and registered op outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      sp_arch_q   <= SP_RESET;
      mem_addr_q  <= '0;
      sp_new_q    <= '0;
      op_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // Commit is independent of enable and of the fault state.
      if (commit_valid) begin
        sp_arch_q <= commit_value;
      end
      op_valid_q <= 1'b0;
      if (fault_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
        state_q     <= StRun;
      end
      if (enable) begin
        unique case (state_q)
          StRun: begin
            if (push_req) begin
              if (push_ok) begin
                mem_addr_q <= eff;
                sp_new_q   <= eff - StepW;
                op_valid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
                state_q    <= StFault;
              end
            end else if (pop_req) begin
              if (pop_ok) begin
                mem_addr_q <= pop_sum[WIDTH-1:0];
                sp_new_q   <= pop_sum[WIDTH-1:0];
                op_valid_q <= 1'b1;
              end else begin
                underflow_q <= 1'b1;
                state_q     <= StFault;
              end
            end
          end
          StFault: begin
            // Ops are ignored until fault_clr returns the FSM to run.
          end
        endcase
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign sp_new    = sp_new_q;
  assign op_valid  = op_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign fault     = (state_q == StFault);

endmodule

// File: doc/sp_fwd_unit.md
Name: sp_fwd_unit

Overview:
- Parametrised stack-pointer forwarding and update unit; successor to the two-stage SP forwarding mux.
- Holds the architectural SP and selects the effective SP from the committed value or up to STAGES in-flight pipeline copies.
- Computes push/pop memory addresses and the next SP, with registered outputs.
- Detects stack overflow and underflow and latches a fault state until software clears it.

Parameters:
- WIDTH, 32: SP/address width.
- STAGES, 2: number of forwarding sources. Index 0 is the youngest stage and has the highest priority.
- SP_RESET, 32'h000FFFFF: SP value after reset. Also the stack top, which is the underflow bound.
- STACK_LIMIT, 32'h000F0000: lowest legal SP, which is the overflow bound.
- STEP, 2: address units per push/pop.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  stage enable. When 0, outputs and the fault FSM hold.
- fwd_valid  in  STAGES  bit i=1: stage i carries a pending SP.
- fwd_value  in  STAGES*WIDTH  pending SP of stage i, in bits [i*WIDTH +: WIDTH].
- commit_valid  in  1  writeback of the architectural SP.
- commit_value  in  WIDTH  value to commit.
- push  in  1  stack push request.
- pop  in  1  stack pop request.
- fault_clr  in  1  clears the fault state.
- mem_addr  out  WIDTH  registered stack memory address.
- sp_new  out  WIDTH  registered updated SP for the pipeline.
- op_valid  out  1  registered; mem_addr/sp_new are valid for an accepted op.
- overflow  out  1  sticky; push below STACK_LIMIT.
- underflow  out  1  sticky; pop above SP_RESET.
- fault  out  1  1 while the FSM is in FAULT.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - sp_arch=SP_RESET.
  - mem_addr=0, sp_new=0, op_valid=0, overflow=0, underflow=0.
  - FSM=RUN, fault=0.
  - Reset asserted mid-operation discards the pending op. No output pulses on deassertion.
- Effective SP (combinational):
  - eff = fwd_value of the lowest index i with fwd_valid[i]=1.
  - If no fwd_valid bit is set, eff = sp_arch.
- Commit:
  - commit_valid=1 loads sp_arch<=commit_value at the clock edge, regardless of enable or FSM state.
  - A commit in the same cycle as an op does not affect that op's eff. The op uses the forwarded or old value.
- Op decode, evaluated only when enable=1 and FSM=RUN:
  - push only: legal if eff >= STACK_LIMIT+STEP. Then mem_addr<=eff, sp_new<=eff-STEP, op_valid<=1.
  - pop only: legal if eff+STEP <= SP_RESET. Then mem_addr<=eff+STEP, sp_new<=eff+STEP, op_valid<=1.
  - push and pop together: illegal-but-benign. op_valid<=0, mem_addr and sp_new hold, no fault.
  - Neither: op_valid<=0, mem_addr and sp_new hold.
  - Arithmetic is WIDTH-bit unsigned. The bound checks use a WIDTH+1-bit compare, so wrap-around can never produce a legal result.
- Illegal op:
  - Illegal push: overflow<=1.
  - Illegal pop: underflow<=1.
  - In either case: op_valid<=0, FSM->FAULT, fault=1 from the next cycle.
- Latency: one cycle from request to op_valid/mem_addr/sp_new. op_valid is a single-cycle pulse per accepted op.
- FSM:
  - RUN -> FAULT on an illegal op.
  - FAULT: push/pop are ignored, op_valid=0, and mem_addr/sp_new hold.
  - FAULT -> RUN on fault_clr=1 at the clock edge. The same edge clears overflow and underflow. The first op is accepted in the cycle after the return.
  - fault_clr in RUN clears any flags and has no other effect.
- enable=0: op_valid<=0. All other outputs and the FSM hold. fault_clr is still honoured.

Test Plan:
- Reset, no forwarding, push -> next cycle mem_addr=0x000FFFFF, sp_new=0x000FFFFD, op_valid=1 for one cycle.
- fwd_valid=2'b11, stage0=0x000F8000, stage1=0x000F9000, pop -> mem_addr=sp_new=0x000F8002 (stage 0 wins). Repeat with fwd_valid=2'b10 -> 0x000F9002.
- commit_value=0x000F0001, then push -> overflow=1, fault=1, op_valid=0. Further push/pop ignored. fault_clr -> flags cleared. Push with eff=0x000F0002 -> sp_new=0x000F0000 accepted.
- Reset, pop with eff=0x000FFFFF -> underflow=1, fault=1. eff=0x000FFFFD pop -> sp_new=0x000FFFFF legal.
- push=pop=1 -> op_valid=0, no fault. enable=0 with push -> op_valid=0, outputs hold. Commit during enable=0 still updates sp_arch, checked by a following pop result.
- Assert rst_n=0 mid-cycle with op pending -> outputs zero immediately, sp_arch=0x000FFFFF, no op_valid after release.
